// File: rtl/pc_rlut_pkg.sv
// Shared definitions for the reverse PC lookup table (pc_rlut).
// Optional feature macro: PC_RLUT_CACHE_EN (last-hit cache in pc_rlut).
package pc_rlut_pkg;
    localparam int D_DEFAULT   = 9;   // target width is D+1 bits
    localparam int NUM_ENTRIES = 32;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;
endpackage

// File: rtl/pc_rlut_if.sv
// Write and lookup signal bundle for pc_rlut; the requester drives the
// master side, the lookup table is the slave.
interface pc_rlut_if #(parameter int D = pc_rlut_pkg::D_DEFAULT);
    import pc_rlut_pkg::*;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [D:0]       wr_target;
    logic             req;
    logic [D:0]       target;
    logic             busy;
    logic             done;
    logic             hit;
    logic [IDX_W-1:0] addr;

    modport master (
        output wr_en, wr_addr, wr_target, req, target,
        input  busy, done, hit, addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_target, req, target,
        output busy, done, hit, addr
    );
endinterface

// File: rtl/pc_rlut_table.sv
// Entry storage for pc_rlut: one write port, one asynchronous indexed read
// port. Only the valid bits are cleared by reset.
module pc_rlut_table
    import pc_rlut_pkg::*;
#(
    parameter int D = D_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [D:0]       wr_target,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [D:0]       rd_target,
    output logic             rd_valid
);
    logic [D:0]             mem_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;

    // Mark the written entry valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        if (wr_en) valid_d[wr_addr] = 1'b1;
    end

    // Valid-bit register, cleared by reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!Reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // Target storage write port.
    always_ff @(posedge Clk) begin
        // NOTE: storage is deliberately not reset; the valid bits alone say which entries exist.
        if (wr_en) mem_q[wr_addr] <= wr_target;
    end

    assign rd_target = mem_q[rd_addr];
    assign rd_valid  = valid_q[rd_addr];
endmodule

// File: rtl/pc_rlut.sv
// Reverse PC lookup: translates a target PC back into the lowest table index
// holding it, scanning one entry per cycle. Define PC_RLUT_CACHE_EN to add
// a last-hit cache that answers a repeated lookup in one cycle.
module pc_rlut
    import pc_rlut_pkg::*;
#(
    parameter int D = D_DEFAULT
) (
    input  logic Clk,
    input  logic Reset_n,
    pc_rlut_if.slave bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [D:0]       tgt_q, tgt_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] addr_q, addr_d;

    logic             wr_commit;
    logic [D:0]       rd_target;
    logic             rd_valid;
    logic             match;
    logic             cache_hit;
    logic [IDX_W-1:0] cache_idx;

    // Writes are only accepted while idle; a busy table stays untouched.
    assign wr_commit = bus.wr_en && (state_q == IDLE);

    pc_rlut_table #(.D(D)) u_table (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .wr_en     (wr_commit),
        .wr_addr   (bus.wr_addr),
        .wr_target (bus.wr_target),
        .rd_addr   (scan_q),
        .rd_target (rd_target),
        .rd_valid  (rd_valid)
    );

    assign match = rd_valid && (rd_target == tgt_q);

`ifdef PC_RLUT_CACHE_EN
    logic             cache_vld_q, cache_vld_d;
    logic [D:0]       cache_tgt_q, cache_tgt_d;
    logic [IDX_W-1:0] cache_idx_q, cache_idx_d;

    // A same-cycle write invalidates the cache, so it cannot answer that req.
    assign cache_hit = cache_vld_q && (cache_tgt_q == bus.target) && !wr_commit;
    assign cache_idx = cache_idx_q;

    // Load on every scan hit, drop on any committed write.
    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_tgt_d = cache_tgt_q;
        cache_idx_d = cache_idx_q;
        if (wr_commit) begin
            cache_vld_d = 1'b0;
        end else if (state_q == SEARCH && match) begin
            cache_vld_d = 1'b1;
            cache_tgt_d = tgt_q;
            cache_idx_d = scan_q;
        end
    end

    // Cache registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cache_vld_q <= 1'b0;
            cache_tgt_q <= '0;
            cache_idx_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_tgt_q <= cache_tgt_d;
            cache_idx_q <= cache_idx_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_idx = '0;
`endif

    // Lookup FSM: next state, scan counter and result registers.
    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        tgt_d   = tgt_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    tgt_d  = bus.target;
                    scan_d = '0;
                    if (cache_hit) begin
                        state_d = DONE;
                        hit_d   = 1'b1;
                        addr_d  = cache_idx;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (match) begin
                    state_d = DONE;
                    hit_d   = 1'b1;
                    addr_d  = scan_q;
                end else if (scan_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = DONE;
                    hit_d   = 1'b0;
                    addr_d  = '0;
                end else begin
                    scan_d = scan_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and result registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            scan_q  <= '0;
            tgt_q   <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.hit  = hit_q;
    assign bus.addr = addr_q;
endmodule

// File: tb/tb_pc_rlut.sv
// Directed bench for pc_rlut. Cycle n is the clock period following edge n-1,
// with req sampled at edge 0; outputs are sampled 1 time unit after each edge.
module tb_pc_rlut;
    import pc_rlut_pkg::*;

    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;

    pc_rlut_if #(.D(9)) bus ();

    pc_rlut #(.D(9)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [9:0] t);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_target = t;
        @(posedge Clk); #1;
        bus.wr_en = 1'b0;
    endtask

    // Issue a lookup and follow it to done; optionally inject an ignored
    // write to entry 7 and a second req during cycle 2.
    task automatic lookup(input string tag, input logic [9:0] tgt, input logic exp_hit,
                          input logic [4:0] exp_addr, input int exp_cyc, input bit inj);
        int cyc;
        logic busy_ok;
        bus.req = 1'b1;
        bus.target = tgt;
        @(posedge Clk); #1;
        bus.req = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (inj && cyc == 2) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 5'd7;
                bus.wr_target = 10'd88;
                bus.req = 1'b1;
                bus.target = 10'd88;
            end else begin
                bus.wr_en = 1'b0;
                bus.req = 1'b0;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        bus.wr_en = 1'b0;
        bus.req = 1'b0;
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_while_searching"}, busy_ok, 1'b1);
        check({tag, " busy_in_done"}, bus.busy, 1'b1);
        check({tag, " hit"}, bus.hit, exp_hit);
        check({tag, " addr"}, bus.addr, exp_addr);
        @(posedge Clk); #1;
        check({tag, " done_single_pulse"}, bus.done, 1'b0);
        check({tag, " busy_after"}, bus.busy, 1'b0);
        check({tag, " hit_held"}, bus.hit, exp_hit);
        check({tag, " addr_held"}, bus.addr, exp_addr);
    endtask

    initial begin
        int cyc;
        logic seen_done;
        int rep_cyc;
        tests = 0;
        fails = 0;
        Reset_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_target = '0;
        bus.req = 1'b0;
        bus.target = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset hit", bus.hit, 1'b0);
        check("reset addr", bus.addr, 5'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Empty table: full scan miss, done in cycle 33.
        lookup("empty_miss", 10'd100, 1'b0, 5'd0, 33, 1'b0);

        // Entry 3 = 23: hit at k=3, done in cycle 5.
        wr(5'd3, 10'd23);
        lookup("hit_e3", 10'd23, 1'b1, 5'd3, 5, 1'b0);

        // Duplicate target 39 at 5 and 20: lowest index wins, cycle 7.
        wr(5'd5, 10'd39);
        wr(5'd20, 10'd39);
        lookup("dup_39", 10'd39, 1'b1, 5'd5, 7, 1'b0);

        // Repeated lookup: one cycle with the cache, full scan without.
        lookup("scan_23", 10'd23, 1'b1, 5'd3, 5, 1'b0);
`ifdef PC_RLUT_CACHE_EN
        rep_cyc = 1;
`else
        rep_cyc = 5;
`endif
        lookup("repeat_23", 10'd23, 1'b1, 5'd3, rep_cyc, 1'b0);
        wr(5'd30, 10'd77);
        lookup("after_wr_23", 10'd23, 1'b1, 5'd3, 5, 1'b0);

        // Simultaneous write and req: the search sees the new entry 0.
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_target = 10'd55;
        lookup("wr_and_req", 10'd55, 1'b1, 5'd0, 2, 1'b0);

        // Write and req while busy are dropped; entry 7 stays invalid.
        lookup("busy_inject", 10'd23, 1'b1, 5'd3, 5, 1'b1);
        lookup("e7_invalid", 10'd88, 1'b0, 5'd0, 33, 1'b0);

        // Load a hit result, then reset in the middle of a search.
        lookup("pre_reset_39", 10'd39, 1'b1, 5'd5, 7, 1'b0);
        bus.req = 1'b1;
        bus.target = 10'd100;
        @(posedge Clk); #1;
        bus.req = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge Clk); #1;
            cyc++;
        end
        check("abort busy_before_reset", bus.busy, 1'b1);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        check("abort hit", bus.hit, 1'b0);
        check("abort addr", bus.addr, 5'd0);
        Reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort no_done", seen_done, 1'b0);
        lookup("post_reset_23", 10'd23, 1'b0, 5'd0, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
